// File: rtl/u2_sm_conv_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : u2_sm_conv_arbiter                                              |
// | Brief    : Round-robin shared U2 -> sign-magnitude converter, 1-deep output|
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module u2_sm_conv_arbiter #(
  parameter int N         = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 req0_valid,
  input  logic [N-1:0]         req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [N-1:0]         req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [N-1:0]         out_data,
  output logic                 out_error,
  output logic                 out_src,
  input  logic                 out_ready,
  input  logic                 clear_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [N-1:0]         C_MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX  = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_grant;
  logic [N-1:0]         r_out_data;
  logic                 r_out_error;
  logic                 r_out_src;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_can_accept;
  logic                 w_grant_any;
  logic                 w_grant_idx;
  logic                 w_accept;
  logic [N-1:0]         w_x;
  logic [N-2:0]         w_mag;
  logic [N-1:0]         w_conv_data;
  logic                 w_conv_error;

  // Grant looks only at the valids, so ready never loops back through itself.
  always_comb begin
    w_grant_any = req0_valid || req1_valid;
    w_grant_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_idx = !r_last_grant;
    end else if (req1_valid) begin
      w_grant_idx = 1'b1;
    end
  end

  assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
  assign req0_ready   = w_grant_any && !w_grant_idx && w_can_accept;
  assign req1_ready   = w_grant_any &&  w_grant_idx && w_can_accept;
  assign w_accept     = w_grant_any && w_can_accept;

  // Low N-1 bits of -x depend only on the low N-1 bits of x.
  assign w_x   = w_grant_idx ? req1_data : req0_data;
  assign w_mag = ~w_x[N-2:0] + (N-1)'(1);

  always_comb begin
    w_conv_data  = w_x;
    w_conv_error = 1'b0;
    if (w_x == C_MOST_NEG) begin
      w_conv_data  = '0;
      w_conv_error = 1'b1;
    end else if (w_x[N-1]) begin
      w_conv_data  = {1'b1, w_mag};
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last_grant <= 1'b1;
      r_out_data   <= '0;
      r_out_error  <= 1'b0;
      r_out_src    <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_idx;
      r_out_data   <= w_conv_data;
      r_out_error  <= w_conv_error;
      r_out_src    <= w_grant_idx;
    end
  end

  // Clear has priority over a same-cycle error increment.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_err_count <= '0;
    end else if (clear_err) begin
      r_err_count <= '0;
    end else if (w_accept && w_conv_error && (r_err_count != C_ERR_MAX)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign busy      = out_valid;
  assign out_data  = r_out_data;
  assign out_error = r_out_error;
  assign out_src   = r_out_src;
  assign err_count = r_err_count;

endmodule

`default_nettype wire
